// File: rtl/gbf_fill_controller_if.sv
// Line-stream handshake between the off-chip loader (master) and a gbf fill controller (slave).
// A beat transfers on every rising clk edge where in_valid && in_ready; in_data is meaningful only then.
interface gbf_fill_controller_if #(
  parameter int DATA_W = 512
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/gbf_fill_controller.sv
// Write-side (port a) fill controller for one double-buffered gbf: streams lines into buf1/buf2 on
// request and reports which buffers hold a complete fill.
module gbf_fill_controller #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gbf1_need_data,
  input  logic                         gbf2_need_data,
  input  logic [GBF_ADDR_BITWIDTH:0]   fill_len,
  gbf_fill_controller_if.slave         s_in,
  output logic                         en1a,
  output logic                         we1a,
  output logic                         en2a,
  output logic                         we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0] addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0] w_data2a,
  output logic                         buf1_ready,
  output logic                         buf2_ready,
  output logic                         data_avail,
  output logic                         fill_busy,
  output logic [1:0]                   fsm_state
);

  localparam int CNT_W = GBF_ADDR_BITWIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(GBF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] len_c;
  logic             pend1, pend2;
  logic             last_buf2;
  logic             need1_q, need2_q;
  logic             rise1, rise2;
  logic             hs;
  logic             pick1, pick2;

  assign len_c = (fill_len == '0 || fill_len > DEPTH_C) ? DEPTH_C : fill_len;
  assign rise1 = gbf1_need_data & ~need1_q;
  assign rise2 = gbf2_need_data & ~need2_q;

  // With both buffers pending, alternate away from the one filled last.
  assign pick2 = pend2 & (~pend1 | ~last_buf2);
  assign pick1 = pend1 & ~pick2;

  assign s_in.in_ready = (state != IDLE) && (cnt != len);
  assign hs            = s_in.in_valid & s_in.in_ready;
  assign fill_busy     = (state != IDLE);
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      pend1      <= 1'b1;
      pend2      <= 1'b1;
      last_buf2  <= 1'b1;
      need1_q    <= 1'b0;
      need2_q    <= 1'b0;
      en1a       <= 1'b0;
      we1a       <= 1'b0;
      en2a       <= 1'b0;
      we2a       <= 1'b0;
      addr1a     <= '0;
      addr2a     <= '0;
      w_data1a   <= '0;
      w_data2a   <= '0;
      buf1_ready <= 1'b0;
      buf2_ready <= 1'b0;
      data_avail <= 1'b0;
    end else begin
      need1_q  <= gbf1_need_data;
      need2_q  <= gbf2_need_data;
      en1a     <= 1'b0;
      we1a     <= 1'b0;
      en2a     <= 1'b0;
      we2a     <= 1'b0;
      addr1a   <= '0;
      addr2a   <= '0;
      w_data1a <= '0;
      w_data2a <= '0;

      if (hs) begin
        if (state == FILL1) begin
          en1a     <= 1'b1;
          we1a     <= 1'b1;
          addr1a   <= cnt[GBF_ADDR_BITWIDTH-1:0];
          w_data1a <= s_in.in_data;
        end else begin
          en2a     <= 1'b1;
          we2a     <= 1'b1;
          addr2a   <= cnt[GBF_ADDR_BITWIDTH-1:0];
          w_data2a <= s_in.in_data;
        end
        cnt <= cnt + CNT_W'(1);
      end

      // A refill request for the buffer being filled right now carries no new information.
      if (rise1 && state != FILL1) begin
        pend1      <= 1'b1;
        buf1_ready <= 1'b0;
      end
      if (rise2 && state != FILL2) begin
        pend2      <= 1'b1;
        buf2_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick1) begin
            state     <= FILL1;
            pend1     <= 1'b0;
            last_buf2 <= 1'b0;
            len       <= len_c;
            cnt       <= '0;
          end else if (pick2) begin
            state     <= FILL2;
            pend2     <= 1'b0;
            last_buf2 <= 1'b1;
            len       <= len_c;
            cnt       <= '0;
          end
        end
        FILL1: begin
          if (cnt == len) begin
            state      <= IDLE;
            buf1_ready <= 1'b1;
            data_avail <= 1'b1;
          end
        end
        FILL2: begin
          if (cnt == len) begin
            state      <= IDLE;
            buf2_ready <= 1'b1;
            data_avail <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbf_fill_controller.sv
// Bench for gbf_fill_controller: behavioural model checked every cycle, plus literal timing pins.
module tb_gbf_fill_controller;
  localparam int DW    = 512;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          gbf1_need_data = 1'b0;
  logic          gbf2_need_data = 1'b0;
  logic [AW:0]   fill_len       = '0;
  logic          en1a, we1a, en2a, we2a;
  logic [AW-1:0] addr1a, addr2a;
  logic [DW-1:0] w_data1a, w_data2a;
  logic          buf1_ready, buf2_ready, data_avail, fill_busy;
  logic [1:0]    fsm_state;

  gbf_fill_controller_if #(.DATA_W(DW)) s_if ();

  gbf_fill_controller #(
    .GBF_DATA_BITWIDTH(DW),
    .GBF_ADDR_BITWIDTH(AW),
    .GBF_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gbf1_need_data(gbf1_need_data),
    .gbf2_need_data(gbf2_need_data),
    .fill_len(fill_len),
    .s_in(s_if.slave),
    .en1a(en1a),
    .we1a(we1a),
    .en2a(en2a),
    .we2a(we2a),
    .addr1a(addr1a),
    .addr2a(addr2a),
    .w_data1a(w_data1a),
    .w_data2a(w_data2a),
    .buf1_ready(buf1_ready),
    .buf2_ready(buf2_ready),
    .data_avail(data_avail),
    .fill_busy(fill_busy),
    .fsm_state(fsm_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // Tracks which buffer is being filled, how many lines have arrived, pending requests,
  // and the write each accepted beat must produce one cycle later.
  bit            model_on = 1'b0;
  bit            m_pend[1:2];
  bit            m_rdy[1:2];
  bit            m_prev[1:2];
  bit            m_avail;
  int            m_last, m_buf, m_len, m_got;
  bit            w_v;
  int            w_buf, w_addr;
  logic [DW-1:0] w_dat;

  always @(posedge clk) begin : model
    bit need_now[1:2];
    bit p_old[1:2];
    bit hs, done;
    int cur, c;
    need_now[1] = gbf1_need_data;
    need_now[2] = gbf2_need_data;
    if (reset) begin
      model_on = 1'b1;
      m_pend[1] = 1'b1; m_pend[2] = 1'b1;
      m_rdy[1] = 1'b0;  m_rdy[2] = 1'b0;
      m_prev[1] = 1'b0; m_prev[2] = 1'b0;
      m_avail = 1'b0; m_last = 2; m_buf = 0; m_len = 0; m_got = 0;
      w_v = 1'b0; w_buf = 0; w_addr = 0; w_dat = '0;
    end else if (model_on) begin
      cur  = m_buf;
      hs   = (cur != 0) && (m_got < m_len) && s_if.in_valid;
      done = (cur != 0) && (m_got == m_len);
      w_v = hs; w_buf = cur; w_addr = m_got; w_dat = s_if.in_data;
      if (hs) m_got++;
      p_old = m_pend;
      for (int n = 1; n <= 2; n++) begin
        if (need_now[n] && !m_prev[n] && cur != n) begin
          m_pend[n] = 1'b1;
          m_rdy[n]  = 1'b0;
        end
        m_prev[n] = need_now[n];
      end
      if (done) begin
        m_rdy[cur] = 1'b1;
        m_avail    = 1'b1;
        m_buf      = 0;
      end else if (cur == 0) begin
        c = 0;
        if (p_old[1] && p_old[2]) c = (m_last == 1) ? 2 : 1;
        else if (p_old[1])        c = 1;
        else if (p_old[2])        c = 2;
        if (c != 0) begin
          m_pend[c] = 1'b0;
          m_last    = c;
          m_buf     = c;
          m_got     = 0;
          m_len     = (fill_len == 0 || int'(fill_len) > DEPTH) ? DEPTH : int'(fill_len);
        end
      end
    end
  end

  // ---------------- per-cycle compare + monitor ----------------
  int rel_cyc = 0;
  int first_rdy1 = -1, first_rdy2 = -1, first_avail = -1;
  int wr1 = 0, wr2 = 0, last_addr1 = -1, last_addr2 = -1;

  always @(negedge clk) begin : compare
    logic [18:0]   exp_ctrl, act_ctrl;
    logic [DW-1:0] exp_d1, exp_d2;
    bit e1, e2;
    if (model_on) begin
      e1 = w_v && (w_buf == 1);
      e2 = w_v && (w_buf == 2);
      exp_ctrl = {(m_buf != 0) && (m_got < m_len), e1, e1, e2, e2,
                  AW'(e1 ? w_addr : 0), AW'(e2 ? w_addr : 0),
                  m_rdy[1], m_rdy[2], m_avail, (m_buf != 0)};
      act_ctrl = {s_if.in_ready, en1a, we1a, en2a, we2a, addr1a, addr2a,
                  buf1_ready, buf2_ready, data_avail, fill_busy};
      exp_d1 = e1 ? w_dat : {DW{1'b0}};
      exp_d2 = e2 ? w_dat : {DW{1'b0}};
      tests++;
      if (act_ctrl !== exp_ctrl) begin
        fails++;
        $display("FAIL ctrl t=%0t got %b expected %b", $time, act_ctrl, exp_ctrl);
      end
      tests++;
      if (w_data1a !== exp_d1 || w_data2a !== exp_d2) begin
        fails++;
        $display("FAIL wdata t=%0t got %h/%h expected %h/%h", $time,
                 w_data1a[63:0], w_data2a[63:0], exp_d1[63:0], exp_d2[63:0]);
      end
    end
    if (buf1_ready === 1'b1 && first_rdy1 < 0) first_rdy1 = rel_cyc;
    if (buf2_ready === 1'b1 && first_rdy2 < 0) first_rdy2 = rel_cyc;
    if (data_avail === 1'b1 && first_avail < 0) first_avail = rel_cyc;
    if (en1a === 1'b1) begin wr1++; last_addr1 = int'(addr1a); end
    if (en2a === 1'b1) begin wr2++; last_addr2 = int'(addr2a); end
    rel_cyc++;
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] cur_data;

  task automatic new_data();
    for (int i = 0; i < DW / 32; i++) cur_data[i*32 +: 32] = $urandom;
  endtask

  // Called just after a rising edge; presents one cycle of stimulus.
  task automatic drive_cycle(input bit v);
    s_if.in_valid = v;
    s_if.in_data  = cur_data;
    @(negedge clk);
    if (v && s_if.in_ready) new_data();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_if.in_valid = 1'b0;
    gbf1_need_data = 1'b0;
    gbf2_need_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rel_cyc = 0;
    first_rdy1 = -1; first_rdy2 = -1; first_avail = -1;
    wr1 = 0; wr2 = 0; last_addr1 = -1; last_addr2 = -1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_both_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!(buf1_ready === 1'b1 && buf2_ready === 1'b1) && n < budget) begin
      drive_cycle(1'b1);
      n++;
    end
    chk({name, "_timeout"}, int'(n < budget), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base1, base2;
    s_if.in_valid = 1'b0;
    new_data();
    s_if.in_data = cur_data;

    // T1: back-to-back beats, fill_len 4: buf1 then buf2 unprompted.
    do_reset();
    fill_len = 6'd4;
    repeat (16) drive_cycle(1'b1);
    chk("t1_buf1_ready_cyc", first_rdy1, 6);
    chk("t1_buf2_ready_cyc", first_rdy2, 12);
    chk("t1_avail_cyc", first_avail, 6);
    chk("t1_writes1", wr1, 4);
    chk("t1_writes2", wr2, 4);
    chk("t1_last_addr1", last_addr1, 3);
    chk("t1_in_ready_after", int'(s_if.in_ready), 0);

    // T2: in_valid toggling, fill_len 3.
    do_reset();
    fill_len = 6'd3;
    for (int i = 0; i < 10; i++) drive_cycle(i % 2 == 0);
    chk("t2_buf1_ready_cyc", first_rdy1, 8);
    chk("t2_writes1", wr1, 3);
    chk("t2_last_addr1", last_addr1, 2);
    wait_both_ready("t2", 200);

    // T3: both ready, request buf2 then buf1 one cycle later.
    gbf2_need_data = 1'b1; drive_cycle(1'b1);
    gbf1_need_data = 1'b1; drive_cycle(1'b1);
    gbf2_need_data = 1'b0; drive_cycle(1'b1);
    gbf1_need_data = 1'b0;
    chk("t3_readies_dropped", int'({buf1_ready, buf2_ready}), 0);
    wait_both_ready("t3", 200);

    // T4: request for buf1 during FILL1 is ignored; during FILL2 it queues another FILL1.
    fill_len = 6'd4;
    base1 = wr1; base2 = wr2;
    gbf1_need_data = 1'b1; drive_cycle(1'b0);
    gbf1_need_data = 1'b0; repeat (3) drive_cycle(1'b0);
    gbf1_need_data = 1'b1; drive_cycle(1'b0);
    gbf1_need_data = 1'b0; drive_cycle(1'b0);
    gbf2_need_data = 1'b1; drive_cycle(1'b0);
    gbf2_need_data = 1'b0; drive_cycle(1'b0);
    repeat (8) drive_cycle(1'b1);
    repeat (3) drive_cycle(1'b0);
    gbf1_need_data = 1'b1; drive_cycle(1'b0);
    gbf1_need_data = 1'b0; drive_cycle(1'b0);
    repeat (30) drive_cycle(1'b1);
    chk("t4_writes1", wr1 - base1, 8);
    chk("t4_writes2", wr2 - base2, 4);

    // T5: fill_len 0 and 40 both clamp to the full depth.
    do_reset();
    fill_len = 6'd0;
    for (int i = 0; i < 70; i++) begin
      if (i == 20) fill_len = 6'd40;
      drive_cycle(1'b1);
    end
    chk("t5_buf1_ready_cyc", first_rdy1, 34);
    chk("t5_buf2_ready_cyc", first_rdy2, 68);
    chk("t5_writes1", wr1, 32);
    chk("t5_writes2", wr2, 32);
    chk("t5_last_addr1", last_addr1, 31);
    chk("t5_last_addr2", last_addr2, 31);

    // T6: reset after 2 of 4 beats; buf1 refilled from scratch.
    do_reset();
    fill_len = 6'd4;
    repeat (3) drive_cycle(1'b1);
    chk("t6_partial_writes", wr1, 1);
    do_reset();
    repeat (8) drive_cycle(1'b1);
    chk("t6_buf1_ready_cyc", first_rdy1, 6);
    chk("t6_writes1", wr1, 4);

    // Randomized traffic: gaps, requests, varying lengths, occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) gbf1_need_data = ~gbf1_need_data;
      if ($urandom_range(0, 19) == 0) gbf2_need_data = ~gbf2_need_data;
      if ($urandom_range(0, 7) == 0)
        fill_len = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
      reset = ($urandom_range(0, 399) == 0);
      drive_cycle($urandom_range(0, 3) != 0);
    end
    reset = 1'b0;
    repeat (4) drive_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
